// File: rtl/spi_ctrl_pkg.sv
// Shared constants for the SPI frame register controller: FSM encoding,
// register addresses and frame field positions.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_WAIT_RX = 2'd2,
    ST_DECODE  = 2'd3
  } state_t;

  localparam int FRAME_ADDR_W = 7;

  localparam logic [FRAME_ADDR_W-1:0] ADDR_CTRL   = 7'd0;
  localparam logic [FRAME_ADDR_W-1:0] ADDR_STATUS = 7'd1;

  localparam int WR_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;

  localparam logic [7:0] CTRL_RST = 8'h03;

endpackage

// File: rtl/spi_reg_bank.sv
// NUM_REGS x 8 register storage with one write port, a read-only STATUS slot
// and two combinational read ports (frame decode and host).
module spi_reg_bank
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = FRAME_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic [7:0]        status_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  input  logic [ADDR_W-1:0] host_addr_i,
  output logic [7:0]        host_data_o,
  output logic [1:0]        freq_o
);

  localparam int AW         = $clog2(NUM_REGS);
  localparam int CTRL_IDX   = int'(ADDR_CTRL);
  localparam int STATUS_IDX = int'(ADDR_STATUS);
  localparam logic [ADDR_W:0]       NUM_A   = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [NUM_REGS-1:0]   RO_MASK = NUM_REGS'(1) << STATUS_IDX;

  logic [7:0] mem_q [NUM_REGS];
  logic       wr_ok;
  logic       rd_valid;
  logic       host_valid;

  assign rd_valid   = {1'b0, rd_addr_i} < NUM_A;
  assign host_valid = {1'b0, host_addr_i} < NUM_A;
  assign wr_ok      = wr_en_i && ({1'b0, wr_addr_i} < NUM_A) && !RO_MASK[wr_addr_i[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= 8'h00;
      end
      mem_q[CTRL_IDX] <= CTRL_RST;
    end else if (wr_ok) begin
      mem_q[wr_addr_i[AW-1:0]] <= wr_data_i;
    end
  end

  // STATUS has no storage of its own; it mirrors the live frame counter.
  assign rd_data_o   = !rd_valid ? 8'h00 :
                       (rd_addr_i == ADDR_STATUS) ? status_i : mem_q[rd_addr_i[AW-1:0]];
  assign host_data_o = !host_valid ? 8'h00 :
                       (host_addr_i == ADDR_STATUS) ? status_i : mem_q[host_addr_i[AW-1:0]];
  assign freq_o      = mem_q[CTRL_IDX][1:0];

endmodule

// File: rtl/spi_frame_reg_ctrl.sv
// Decodes received SPI frames as register reads/writes, queues read responses
// for the next frame and arms the SPI block between frames.
//   state      | meaning
//   IDLE       | wait for cs_bar high before arming
//   ARM        | one-cycle start pulse to the SPI block
//   WAIT_RX    | frame in flight, capture on rx_valid
//   DECODE     | apply write or load read response
module spi_frame_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int         NUM_REGS = 16,
  parameter int         ADDR_W   = FRAME_ADDR_W,
  parameter logic [7:0] RESP_ERR = 8'hEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mosi_reg_data,
  input  logic        rx_valid,
  input  logic        tx_done,
  input  logic        cs_bar,
  output logic        slave_rx_start,
  output logic        slave_tx_start,
  output logic [15:0] miso_reg_data,
  output logic [1:0]  freq_control,
  input  logic [3:0]  host_addr,
  output logic [7:0]  host_rdata,
  output logic        frame_err,
  input  logic        err_clr
);

  localparam logic [ADDR_W:0] NUM_A = (ADDR_W + 1)'(NUM_REGS);

  state_t      state_q, state_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] miso_q, miso_d;
  logic        tx_pending_q, tx_pending_d;
  logic        err_q, err_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;

  logic              is_wr;
  logic [ADDR_W-1:0] dec_addr;
  logic [7:0]        dec_data;
  logic              addr_valid;
  logic              addr_ro;
  logic              bank_wr;
  logic [7:0]        bank_rdata;
  logic              err_set;

  assign is_wr      = frame_q[WR_BIT];
  assign dec_addr   = frame_q[ADDR_MSB:ADDR_LSB];
  assign dec_data   = frame_q[7:0];
  assign addr_valid = {1'b0, dec_addr} < NUM_A;
  assign addr_ro    = dec_addr == ADDR_STATUS;
  assign bank_wr    = (state_q == ST_DECODE) && is_wr && addr_valid && !addr_ro;

  spi_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (bank_wr),
    .wr_addr_i   (dec_addr),
    .wr_data_i   (dec_data),
    .status_i    ({4'b0000, rx_cnt_q}),
    .rd_addr_i   (dec_addr),
    .rd_data_o   (bank_rdata),
    .host_addr_i ({{(ADDR_W-4){1'b0}}, host_addr}),
    .host_data_o (host_rdata),
    .freq_o      (freq_control)
  );

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    miso_d       = miso_q;
    tx_pending_d = tx_pending_q;
    err_set      = 1'b0;
    rx_cnt_d     = rx_valid ? rx_cnt_q + 4'd1 : rx_cnt_q;

    if (tx_done) begin
      tx_pending_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_bar) state_d = ST_ARM;
      end
      // A chip select that drops during ARM aborts the pulse rather than
      // leaving the FSM waiting on a frame that was never started.
      ST_ARM: begin
        state_d = cs_bar ? ST_WAIT_RX : ST_IDLE;
      end
      ST_WAIT_RX: begin
        if (rx_valid) begin
          frame_d = mosi_reg_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (is_wr) begin
          err_set = !addr_valid || addr_ro;
        end else begin
          miso_d       = {1'b0, dec_addr, addr_valid ? bank_rdata : RESP_ERR};
          tx_pending_d = 1'b1;
          err_set      = !addr_valid;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      frame_q      <= 16'h0000;
      miso_q       <= 16'h0000;
      tx_pending_q <= 1'b0;
      err_q        <= 1'b0;
      rx_cnt_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      miso_q       <= miso_d;
      tx_pending_q <= tx_pending_d;
      err_q        <= err_d;
      rx_cnt_q     <= rx_cnt_d;
    end
  end

  assign slave_rx_start = (state_q == ST_ARM) && cs_bar;
  assign slave_tx_start = slave_rx_start && tx_pending_q;
  assign miso_reg_data  = miso_q;
  assign frame_err      = err_q;

endmodule
